core_instr_fifo: RTL and testbench
==================================

# core_instr_fifo

Per-core instruction queue between the dual-core dispatch arbiter and each pipelined core; one instance per core. Buffers dispatched 32-bit instructions in order, presents the head to the core's fetch stage with a valid/ready handshake, and exports a hazard-match flag. The arbiter uses the flag to route dependent instructions to the queue holding their producer.

## Interface
- `DEPTH`, 32: number of entries; power of two, ≥ 2.
- `WIDTH`, 32: instruction width; field rules below assume 32.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  arbiter offers `in_instr`.
- `in_instr`  in  WIDTH  instruction to enqueue.
- `in_ready`  out  1  queue can accept; equals !full.
- `out_valid`  out  1  head entry present; equals !empty.
- `out_instr`  out  WIDTH  head entry, show-ahead; 0 when empty.
- `out_ready`  in  1  core consumes head.
- `flush`  in  1  discard all entries.
- `query_instr`  in  WIDTH  instruction the arbiter is routing.
- `hazard_hit`  out  1  query depends on a queued entry (combinational).
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky: push attempted while full.

## Operation
- Circular buffer: write pointer, read pointer, `count`; pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0. A per-entry valid bit is set on write and cleared on read/flush.
- Push: `in_valid && in_ready` writes `in_instr` at wptr, advances wptr, and increments count.
- Pop: `out_valid && out_ready` clears the head valid bit, advances rptr, and decrements count.
- Simultaneous push and pop with 0 < count < DEPTH: both occur; count unchanged.
- Full (count == DEPTH): `in_ready` = 0 even if a pop occurs the same cycle. A push offered while full is dropped and sets `overflow`.
- Empty: `out_valid` = 0 and `out_ready` is ignored. Push into empty is visible on `out_instr` the next cycle; there is no same-cycle bypass.
- Priority per edge: reset > flush > push/pop. Flush zeroes the pointers, count and all valid bits, and ignores the same-cycle push. `overflow` is unaffected by flush.
- Instruction fields: [27] forced route, [26] forced core, [23] src mode, [22] dest mode, [21:11] dest addr, [10:0] src addr.
- Hazard match for each valid entry e (q = query_instr), any of:
  - {q[23],q[10:0]} == {e[22],e[21:11]}
  - {q[22],q[21:11]} == {e[23],e[10:0]}
  - {q[22],q[21:11]} == {e[22],e[21:11]}
- `hazard_hit` = OR over valid entries, forced to 0 when q[23] && q[22]. Invalid or stale slots never match.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `out_instr` 0, `count` 0, `overflow` 0, `hazard_hit` 0. Storage contents are don't-care but gated by the valid bits.
- Enqueue-to-head latency: 1 cycle from accepting edge when empty.
- `count`, `in_ready`, `out_valid` are registered-state-derived and update the cycle after the edge.
- `hazard_hit` is combinational from `query_instr` and current state. An entry being popped on this edge still participates; an entry being pushed this edge does not.
- Reset or flush asserted mid-stream takes effect on that edge; the next cycle shows the reset values (except `overflow` on flush).

## Configuration
- `CORE_FIFO_HAZARD_EN` defined: per-entry comparators and `hazard_hit` logic are built as above.
- Not defined: no comparators are built, `hazard_hit` is tied to 0, and `query_instr` is unused. The arbiter then relies only on forced routing and alternation.

## Test plan
- Reset, then push 0x0000_0801, 0x0000_1002, 0x0000_1803; pop with `out_ready` held 1 -> `out_instr` sequence 0x801, 0x1002, 0x1803; `count` 1,2,3 then 2,1,0; `out_valid` drops after the third pop.
- Fill DEPTH=32 entries, then offer a 33rd push -> `in_ready` 0, entry dropped, `overflow` 1 and sticky until reset; the head is still the first entry.
- With count=5, push and pop on the same edge for 40 cycles -> `count` stays 5, FIFO order is preserved across pointer wrap.
- Queue holds e=0x0000_2800 (dest {0,5}); query 0x0000_0005 (src {0,5}) -> `hazard_hit` 1. Query 0x00C0_0005 -> 0. With macro undefined -> always 0.
- Queue 3 entries, assert `flush` together with `in_valid` -> next cycle `count` 0, `out_valid` 0, the flushed entries no longer raise `hazard_hit`, and the pushed instruction is absent.
- Assert `reset` on the same edge as a push and pop at count=4 -> next cycle all outputs at their reset values.

Source files
------------

// File: rtl/core_instr_fifo.sv
// rtl/core_instr_fifo.sv - per-core in-order instruction queue with hazard-match flag
// Optional feature: CORE_FIFO_HAZARD_EN builds the per-entry hazard comparators.
module core_instr_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           query_instr,
  output logic                       hazard_hit,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // a pop on the same edge never frees room for a push while full
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_instr = empty ? '0 : mem_q[rptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    vld_d      = vld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid && full);
    if (flush) begin
      vld_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = in_instr;
        vld_d[wptr_q] = 1'b1;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
        vld_d[rptr_q] = 1'b0;
        rptr_d        = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // storage needs no reset: every read is gated by count or the valid bits
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef CORE_FIFO_HAZARD_EN
  logic hit;
  always_comb begin
    hit = 1'b0;
    if (!(query_instr[23] && query_instr[22])) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (vld_q[e] &&
            (({query_instr[23], query_instr[10:0]}  == {mem_q[e][22], mem_q[e][21:11]}) ||
             ({query_instr[22], query_instr[21:11]} == {mem_q[e][23], mem_q[e][10:0]})  ||
             ({query_instr[22], query_instr[21:11]} == {mem_q[e][22], mem_q[e][21:11]})))
          hit = 1'b1;
      end
    end
  end
  assign hazard_hit = hit;
`else
  logic unused_hazard;
  assign unused_hazard = ^{query_instr, vld_q};
  assign hazard_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_core_instr_fifo.sv
// tb/tb_core_instr_fifo.sv - directed table and sequence checks for core_instr_fifo
module tb_core_instr_fifo;
  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
`ifdef CORE_FIFO_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, flush;
  logic [WIDTH-1:0] in_instr, query_instr;
  logic in_ready, out_valid, hazard_hit, overflow;
  logic [WIDTH-1:0] out_instr;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int passed = 0;

  core_instr_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_ready(out_ready), .flush(flush), .query_instr(query_instr),
    .hazard_hit(hazard_hit), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ii;
    logic        ordy;
    logic        fl;
    logic [31:0] q;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_oi;
    int          e_cnt;
    logic        e_ovf;
    logic        e_hz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ii,
                       input logic ordy, input logic fl, input logic [31:0] q);
    reset = r; in_valid = iv; in_instr = ii; out_ready = ordy; flush = fl; query_instr = q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic irdy, input logic ov,
                           input logic [31:0] oi, input int cnt, input logic ovf, input logic hz);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(irdy));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_instr"}, out_instr, oi);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    check({tag, ".hazard_hit"}, 32'(hazard_hit), 32'(hz));
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic add(input logic iv, input logic [31:0] ii, input logic ordy, input logic fl,
                     input logic [31:0] q, input logic irdy, input logic ov,
                     input logic [31:0] oi, input int cnt, input logic ovf, input logic hz);
    vec_t v;
    v = '{rst: 1'b0, iv: iv, ii: ii, ordy: ordy, fl: fl, q: q, e_irdy: irdy, e_ov: ov,
          e_oi: oi, e_cnt: cnt, e_ovf: ovf, e_hz: hz};
    vecs.push_back(v);
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;

    // expected outputs are those seen before the edge that applies the inputs
    add(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    0, 0, 0);
    add(1, 32'h0000_0801, 0, 0, 32'h0,         1, 0, 32'h0,    0, 0, 0);
    add(1, 32'h0000_1002, 0, 0, 32'h0,         1, 1, 32'h801,  1, 0, 0);
    add(1, 32'h0000_1803, 0, 0, 32'h0,         1, 1, 32'h801,  2, 0, 0);
    add(0, 32'h0,         0, 0, 32'h5,         1, 1, 32'h801,  3, 0, 0);
    add(0, 32'h0,         0, 0, 32'h2,         1, 1, 32'h801,  3, 0, HZ);
    add(0, 32'h0,         0, 0, 32'h1800,      1, 1, 32'h801,  3, 0, HZ);
    add(0, 32'h0,         0, 0, 32'h00C0_0002, 1, 1, 32'h801,  3, 0, 0);
    add(0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h801,  3, 0, 0);
    add(0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h1002, 2, 0, 0);
    add(0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h1803, 1, 0, 0);
    add(0, 32'h0,         1, 0, 32'h2,         1, 0, 32'h0,    0, 0, 0);
    add(1, 32'h0000_2800, 0, 0, 32'h5,         1, 0, 32'h0,    0, 0, 0);
    add(0, 32'h0,         1, 0, 32'h5,         1, 1, 32'h2800, 1, 0, HZ);
    add(1, 32'h0000_2800, 0, 0, 32'h5,         1, 0, 32'h0,    0, 0, 0);
    add(0, 32'h0,         0, 0, 32'h00C0_0005, 1, 1, 32'h2800, 1, 0, 0);
    add(0, 32'h0,         0, 0, 32'h5,         1, 1, 32'h2800, 1, 0, HZ);

    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ii, vecs[i].ordy, vecs[i].fl, vecs[i].q);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_oi,
                vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_hz);
      tick();
    end

    // fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_all("full", 0, 1, 32'h100, DEPTH, 0, 0);
    drive(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0);
    tick();
    check_all("ovf", 0, 1, 32'h100, DEPTH, 1, 0);
    drive(1'b0, 1'b1, 32'hBEEF, 1'b1, 1'b0, 32'h0);
    #1;
    check("full_pop.in_ready", 32'(in_ready), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_all("full_pop", 1, 1, 32'h101, DEPTH - 1, 1, 0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_all("ovf_flush", 1, 0, 32'h0, 0, 1, 0);
    do_reset();
    check("ovf_reset.overflow", 32'(overflow), 32'h0);

    // steady push+pop at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 32'h205 + 32'(i), 1'b1, 1'b0, 32'h0);
      #1;
      check($sformatf("wrap%0d.out_instr", i), out_instr, 32'h200 + 32'(i));
      tick();
      check($sformatf("wrap%0d.count", i), 32'(count), 32'd5);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check("wrap_end.out_instr", out_instr, 32'h228);

    // flush with three entries and a concurrent push
    do_reset();
    drive(1'b0, 1'b1, 32'h0000_2800, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h0000_0801, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h0000_1002, 1'b0, 1'b0, 32'h5); tick();
    #1;
    check("pre_flush.hazard_hit", 32'(hazard_hit), 32'(HZ));
    drive(1'b0, 1'b1, 32'h0000_3333, 1'b0, 1'b1, 32'h5);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5);
    #1;
    check_all("flush", 1, 0, 32'h0, 0, 0, 0);
    tick();
    check("flush_absent.count", 32'(count), 32'h0);

    // reset on the same edge as push+pop at count 4, with overflow set beforehand
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, 1'b1, 32'h0000_2800, 1'b0, 1'b0, 32'h0);
      tick();
    end
    for (int i = 0; i < DEPTH - 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5);
    #1;
    check("pre_reset.count", 32'(count), 32'd4);
    check("pre_reset.overflow", 32'(overflow), 32'h1);
    drive(1'b1, 1'b1, 32'h0000_0777, 1'b1, 1'b0, 32'h5);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5);
    #1;
    check_all("reset_mid", 1, 0, 32'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
